// File: rtl/plot_arb_pkg.sv
// rtl/plot_arb_pkg.sv - shared state type and pixel field widths for the plot arbiter
package plot_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting one past the last winner
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_winner,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Scan farthest-first so the nearest requester after last_winner is written last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_winner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin owner of the VGA plot port; PLOT_ARB_TIMEOUT_EN adds a grant watchdog
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   plot,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour_out,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [C_W-1:0]     col_q, col_d;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               rel_norm;

`ifdef PLOT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_err_q, tmo_err_d;
  logic          tmo_fire;
`endif

  rr_picker #(
    .NUM_REQ    (NUM_REQ),
    .IW         (IW)
  ) u_rr_picker (
    .req        (req),
    .last_winner(last_q),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    rel_norm = done[gidx_q] || !req[gidx_q];
`ifdef PLOT_ARB_TIMEOUT_EN
    cnt_d     = '0;
    tmo_err_d = 1'b0;
    tmo_fire  = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT_CYC - 1)) && !rel_norm;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gidx_d  = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (pick_idx == IW'(i));
        end
      end
      GRANT: begin
        plot_d = plot_in[gidx_q];
        x_d    = x_in[gidx_q*X_W +: X_W];
        y_d    = y_in[gidx_q*Y_W +: Y_W];
        col_d  = colour_in[gidx_q*C_W +: C_W];
`ifdef PLOT_ARB_TIMEOUT_EN
        cnt_d     = cnt_q + 1'b1;
        tmo_err_d = tmo_fire;
        if (rel_norm || tmo_fire) begin
`else
        if (rel_norm) begin
`endif
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
`ifdef PLOT_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
`ifdef PLOT_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign plot       = plot_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour_out = col_q;
  assign busy       = (state_q == GRANT);
`ifdef PLOT_ARB_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
